mult_job_sequencer: RTL and testbench

Sequencer that sits directly upstream of the 4-bit sequential `Multiplier` and owns its control pins. It accepts operand pairs over a valid/ready handshake and buffers them in a small FIFO. For each job it issues one `rst` pulse and one `start` pulse, waits the fixed multiply latency, then captures `product` and returns it with a job tag on a valid/ready result port.

---
 rtl/mult_job_sequencer_pkg.sv | 18 +
 rtl/mult_job_sequencer_if.sv | 28 ++
 rtl/mult_job_sequencer_op_fifo.sv | 72 +++++++
 rtl/mult_job_sequencer.sv | 155 +++++++++++++++
 tb/tb_mult_job_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_job_sequencer_pkg.sv
// Shared types and default sizing for the multiplier job sequencer.
package mult_seq_pkg;

   localparam int unsigned W_DEF           = 4;
   localparam int unsigned TAG_W_DEF       = 4;
   localparam int unsigned PROD_W_DEF      = 2 * W_DEF + 1;
   localparam int unsigned DEPTH_DEF       = 2;
   localparam int unsigned MUL_LATENCY_DEF = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLR,
      ST_START,
      ST_WAIT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/mult_job_sequencer_if.sv
// Operand-in and result-out handshakes of the job sequencer.
interface mult_job_sequencer_if
   import mult_seq_pkg::*;
#(
   parameter int unsigned W     = W_DEF,
   parameter int unsigned TAG_W = TAG_W_DEF
) ();

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic             res_valid;
   logic             res_ready;
   logic [2*W:0]     res_product;
   logic [TAG_W-1:0] res_tag;

   modport master (
      output in_valid, in_a, in_b, res_ready,
      input  in_ready, res_valid, res_product, res_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, res_ready,
      output in_ready, res_valid, res_product, res_tag
   );

endinterface

// File: rtl/mult_job_sequencer_op_fifo.sv
// Small synchronous FIFO holding {tag, a, b} jobs; full/empty flags are registered.
module op_fifo #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic              rd_valid_nxt_c
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_ready_q, wr_ready_d;
   logic              rd_valid_q, rd_valid_d;
   logic              do_push, do_pop;

   // Next-state for storage, pointers, occupancy and flags.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_push  = push && wr_ready_q;
      do_pop   = pop && rd_valid_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      wr_ready_d = (count_d != CNT_W'(DEPTH));
      rd_valid_d = (count_d != '0);
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         wr_ready_q <= 1'b1;
         rd_valid_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         wr_ready_q <= wr_ready_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data        = mem_q[rd_ptr_q];
   assign wr_ready       = wr_ready_q;
   assign rd_valid       = rd_valid_q;
   assign rd_valid_nxt_c = rd_valid_d;

endmodule

// File: rtl/mult_job_sequencer.sv
// Drives the sequential multiplier's rst/start pins per queued job and returns tagged products.
module mult_job_sequencer
   import mult_seq_pkg::*;
#(
   parameter int unsigned W           = W_DEF,
   parameter int unsigned DEPTH       = DEPTH_DEF,
   parameter int unsigned MUL_LATENCY = MUL_LATENCY_DEF,
   parameter int unsigned TAG_W       = TAG_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   mult_job_sequencer_if.slave bus,
   output logic                mul_rst,
   output logic                mul_start,
   output logic [W-1:0]        mul_multiplier,
   output logic [W-1:0]        mul_multiplicand,
   input  logic [2*W:0]        mul_product,
   output logic                busy
);

   localparam int unsigned PROD_W = 2 * W + 1;
   localparam int unsigned DATA_W = TAG_W + 2 * W;
   localparam int unsigned CNT_W  = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [TAG_W-1:0]    tag_cnt_q, tag_cnt_d;
   logic [TAG_W-1:0]    job_tag_q, job_tag_d;
   logic [W-1:0]        op_a_q, op_a_d;
   logic [W-1:0]        op_b_q, op_b_d;
   logic                res_valid_q, res_valid_d;
   logic [PROD_W-1:0]   res_product_q, res_product_d;
   logic [TAG_W-1:0]    res_tag_q, res_tag_d;
   logic                mul_rst_q, mul_rst_d;
   logic                mul_start_q, mul_start_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   fifo_wr_data;
   logic [DATA_W-1:0]   fifo_rd_data;
   logic                fifo_ready;
   logic                fifo_valid;
   logic                fifo_valid_nxt;
   logic                fifo_pop;
   logic                accept;

   assign fifo_wr_data = {tag_cnt_q, bus.in_a, bus.in_b};
   assign accept       = bus.in_valid && fifo_ready;

   op_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_op_fifo (
      .clk            (clk),
      .rst            (rst),
      .push           (bus.in_valid),
      .pop            (fifo_pop),
      .wr_data        (fifo_wr_data),
      .rd_data        (fifo_rd_data),
      .wr_ready       (fifo_ready),
      .rd_valid       (fifo_valid),
      .rd_valid_nxt_c (fifo_valid_nxt)
   );

   // Job FSM, latency counter, tag counter and registered output decode.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tag_cnt_d     = tag_cnt_q;
      job_tag_d     = job_tag_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      res_product_d = res_product_q;
      res_tag_d     = res_tag_q;
      fifo_pop      = 1'b0;

      if (accept) tag_cnt_d = tag_cnt_q + TAG_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (fifo_valid) begin
               fifo_pop  = 1'b1;
               job_tag_d = fifo_rd_data[DATA_W-1 -: TAG_W];
               op_a_d    = fifo_rd_data[2*W-1 -: W];
               op_b_d    = fifo_rd_data[W-1:0];
               state_d   = ST_CLR;
            end
         end
         ST_CLR: state_d = ST_START;
         ST_START: begin
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               res_product_d = mul_product;
               res_tag_d     = job_tag_q;
               state_d       = ST_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (bus.res_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      res_valid_d = (state_d == ST_DONE);
      mul_rst_d   = (state_d == ST_CLR);
      mul_start_d = (state_d == ST_START);
      busy_d      = (state_d != ST_IDLE) || fifo_valid_nxt;
   end

   // Sequencer state and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         tag_cnt_q     <= '0;
         job_tag_q     <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         res_valid_q   <= 1'b0;
         res_product_q <= '0;
         res_tag_q     <= '0;
         mul_rst_q     <= 1'b0;
         mul_start_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tag_cnt_q     <= tag_cnt_d;
         job_tag_q     <= job_tag_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         res_valid_q   <= res_valid_d;
         res_product_q <= res_product_d;
         res_tag_q     <= res_tag_d;
         mul_rst_q     <= mul_rst_d;
         mul_start_q   <= mul_start_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.in_ready     = fifo_ready;
   assign bus.res_valid    = res_valid_q;
   assign bus.res_product  = res_product_q;
   assign bus.res_tag      = res_tag_q;
   assign mul_rst          = mul_rst_q;
   assign mul_start        = mul_start_q;
   assign mul_multiplier   = op_a_q;
   assign mul_multiplicand = op_b_q;
   assign busy             = busy_q;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural 10-cycle multiplier model.
module tb_mult_job_sequencer;

   localparam int unsigned W     = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned LAT   = 10;
   localparam int unsigned PW    = 2 * W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          mul_rst, mul_start, busy;
   logic [W-1:0]  mul_multiplier, mul_multiplicand;
   logic [PW-1:0] mul_product;

   mult_job_sequencer_if #(.W(W), .TAG_W(TAG_W)) bus ();

   mult_job_sequencer #(
      .W           (W),
      .DEPTH       (2),
      .MUL_LATENCY (LAT),
      .TAG_W       (TAG_W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (bus),
      .mul_rst          (mul_rst),
      .mul_start        (mul_start),
      .mul_multiplier   (mul_multiplier),
      .mul_multiplicand (mul_multiplicand),
      .mul_product      (mul_product),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   // Cycle and pulse counters.
   int unsigned cyc = 0, n_rst_p = 0, n_start_p = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mul_rst)   n_rst_p   <= n_rst_p + 1;
      if (mul_start) n_start_p <= n_start_p + 1;
   end

   // Multiplier model: product is junk after start and only correct LAT cycles after start drops.
   logic [PW-1:0] m_prod;
   int            m_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_prod <= '0;
         m_cnt  <= 0;
      end else if (mul_rst) begin
         m_prod <= '0;
         m_cnt  <= 0;
      end else if (mul_start) begin
         m_prod <= PW'(9'h1AA);
         m_cnt  <= LAT;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 2) m_prod <= PW'(mul_multiplier) * PW'(mul_multiplicand);
      end
   end
   assign mul_product = m_prod;

   int n_tests = 0, n_fail = 0;
   int unsigned acc_cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      tick();
      #3 rst = 1'b1;
      tick();
   endtask

   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      logic rdy;
      bit   ok;
      ok = 1'b0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rdy = bus.in_ready;
         tick();
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      acc_cyc = cyc;
      if (!hold) bus.in_valid = 1'b0;
      if (!ok) check("accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_result(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (bus.res_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      if (!seen) check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int unsigned c1, s0, r0;
      bit held_ok;

      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.res_ready = 1'b0;

      // Async reset values before any clock edge.
      #2 rst = 1'b0;
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_res_product", 32'(bus.res_product), 32'd0);
      check("rst_res_tag", 32'(bus.res_tag), 32'd0);
      check("rst_mul_rst", 32'(mul_rst), 32'd0);
      check("rst_mul_start", 32'(mul_start), 32'd0);
      check("rst_mul_ops", 32'({mul_multiplier, mul_multiplicand}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      tick();
      #3 rst = 1'b1;
      tick();

      // Single job 6x3.
      bus.res_ready = 1'b1;
      s0 = n_start_p;
      r0 = n_rst_p;
      accept(4'd6, 4'd3, 1'b0);
      tick();
      check("single_mul_rst_hi", 32'(mul_rst), 32'd1);
      check("single_mul_start_lo", 32'(mul_start), 32'd0);
      check("single_ops", 32'({mul_multiplier, mul_multiplicand}), 32'h63);
      tick();
      check("single_mul_rst_lo", 32'(mul_rst), 32'd0);
      check("single_mul_start_hi", 32'(mul_start), 32'd1);
      wait_result("single_timeout");
      check("single_latency", cyc - acc_cyc, 32'd13);
      check("single_product", 32'(bus.res_product), 32'd18);
      check("single_tag", 32'(bus.res_tag), 32'd0);
      tick();
      tick();
      check("single_rst_pulses", n_rst_p - r0, 32'd1);
      check("single_start_pulses", n_start_p - s0, 32'd1);
      check("single_busy_idle", 32'(busy), 32'd0);

      // Back-to-back with in_valid held.
      do_reset();
      bus.res_ready = 1'b1;
      accept(4'd15, 4'd15, 1'b1);
      accept(4'd0, 4'd12, 1'b1);
      accept(4'd1, 4'd2, 1'b0);
      check("b2b_in_ready_full", 32'(bus.in_ready), 32'd0);
      check("b2b_busy", 32'(busy), 32'd1);
      wait_result("b2b_to0");
      check("b2b_p0", 32'(bus.res_product), 32'd225);
      check("b2b_t0", 32'(bus.res_tag), 32'd0);
      c1 = cyc;
      tick();
      wait_result("b2b_to1");
      check("b2b_p1", 32'(bus.res_product), 32'd0);
      check("b2b_t1", 32'(bus.res_tag), 32'd1);
      check("b2b_throughput", cyc - c1, 32'd14);
      tick();
      wait_result("b2b_to2");
      check("b2b_p2", 32'(bus.res_product), 32'd2);
      check("b2b_t2", 32'(bus.res_tag), 32'd2);
      tick();

      // Backpressure on the result port.
      do_reset();
      bus.res_ready = 1'b0;
      accept(4'd5, 4'd7, 1'b1);
      accept(4'd3, 4'd4, 1'b1);
      accept(4'd2, 4'd9, 1'b0);
      wait_result("bp_to0");
      check("bp_p0", 32'(bus.res_product), 32'd35);
      check("bp_t0", 32'(bus.res_tag), 32'd0);
      s0 = n_start_p;
      held_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (!(bus.res_valid === 1'b1 && bus.res_product === PW'(35) && bus.res_tag === TAG_W'(0)))
            held_ok = 1'b0;
      end
      check("bp_held_stable", 32'(held_ok), 32'd1);
      check("bp_no_start", n_start_p - s0, 32'd0);
      check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
      bus.res_ready = 1'b1;
      tick();
      wait_result("bp_to1");
      check("bp_p1", 32'(bus.res_product), 32'd12);
      check("bp_t1", 32'(bus.res_tag), 32'd1);
      tick();
      wait_result("bp_to2");
      check("bp_p2", 32'(bus.res_product), 32'd18);
      check("bp_t2", 32'(bus.res_tag), 32'd2);
      tick();
      check("bp_busy_done", 32'(busy), 32'd0);

      // Async reset during WAIT, with a second job queued.
      do_reset();
      bus.res_ready = 1'b1;
      accept(4'd9, 4'd9, 1'b1);
      accept(4'd8, 4'd8, 1'b0);
      repeat (5) tick();
      check("ar_busy_before", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("ar_in_ready", 32'(bus.in_ready), 32'd1);
      check("ar_res_valid", 32'(bus.res_valid), 32'd0);
      check("ar_res_product", 32'(bus.res_product), 32'd0);
      check("ar_mul_pins", 32'({mul_rst, mul_start}), 32'd0);
      check("ar_mul_ops", 32'({mul_multiplier, mul_multiplicand}), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      tick();
      #3 rst = 1'b1;
      tick();
      held_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus.res_valid !== 1'b0 || busy !== 1'b0) held_ok = 1'b0;
         tick();
      end
      check("ar_no_stale_result", 32'(held_ok), 32'd1);
      accept(4'd2, 4'd2, 1'b0);
      wait_result("ar_to");
      check("ar_product", 32'(bus.res_product), 32'd4);
      check("ar_tag", 32'(bus.res_tag), 32'd0);
      tick();

      // Tag wrap over 17 jobs.
      do_reset();
      bus.res_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         accept(4'd1, 4'd1, 1'b0);
         wait_result("wrap_to");
         check($sformatf("wrap_tag_%0d", i), 32'(bus.res_tag), 32'(i % 16));
         check($sformatf("wrap_prod_%0d", i), 32'(bus.res_product), 32'd1);
         tick();
      end

      // Zero operands.
      accept(4'd0, 4'd0, 1'b0);
      wait_result("zero_to");
      check("zero_latency", cyc - acc_cyc, 32'd13);
      check("zero_product", 32'(bus.res_product), 32'd0);
      check("zero_tag", 32'(bus.res_tag), 32'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
